// File: rtl/mainbus_burst_mem_if.sv
// rtl/mainbus_burst_mem_if.sv - multiplexed main bus: shared address/data, strobes and slave status
interface mainbus_burst_mem_if #(
    parameter int DATA_W = 16
);
    wire  [DATA_W-1:0] AddrData;
    logic              AddrValid;
    logic              rw;
    logic [DATA_W-1:0] masterData;
    logic              masterOe;
    logic [DATA_W-1:0] readData;
    logic              readOe;
    logic              busy;
    logic              proto_err;

    // Both sides resolve onto the shared bus here; a side that is not enabled floats its driver.
    assign AddrData = masterOe ? masterData : 'z;
    assign AddrData = readOe   ? readData   : 'z;

    modport master (
        output AddrValid, rw, masterData, masterOe,
        input  AddrData, readOe, busy, proto_err
    );

    modport slave (
        input  AddrValid, rw, AddrData,
        output readData, readOe, busy, proto_err
    );
endinterface

// File: rtl/mainbus_burst_mem.sv
// rtl/mainbus_burst_mem.sv - paged burst memory slave on the multiplexed main bus
module mainbus_burst_mem #(
    parameter int DATA_W    = 16,
    parameter int PAGE_BITS = 4,
    parameter int PAGE_ID   = 0,
    parameter int BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               resetH,
    mainbus_burst_mem_if.slave bus
);
    localparam int OFF_W  = DATA_W - PAGE_BITS;
    localparam int DEPTH  = 1 << OFF_W;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [PAGE_BITS-1:0] PAGE      = PAGE_BITS'(PAGE_ID);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, WRITE, TURN, READ} state_t;

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic [OFF_W-1:0]  base;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [PAGE_BITS-1:0] addrPage;
    logic [OFF_W-1:0]     addrOff;
    logic [OFF_W-1:0]     beatAddr;
    logic [OFF_W-1:0]     fetchAddr;
    logic                 pageHit;
    logic                 lastBeat;

    assign addrPage = bus.AddrData[DATA_W-1 -: PAGE_BITS];
    assign addrOff  = bus.AddrData[OFF_W-1:0];
    assign pageHit  = (addrPage == PAGE);
    assign lastBeat = (beat == LAST_BEAT);
    // Offset arithmetic is OFF_W wide, so bursts wrap inside the page and never touch the page bits.
    assign beatAddr = base + OFF_W'(beat);
    // Read data is registered one cycle ahead: TURN fetches beat 0, each READ beat fetches the next.
    assign fetchAddr = (state == READ) ? beatAddr + OFF_W'(1) : base;

    // Write beats land in memory; a reset edge abandons the beat in flight.
    always_ff @(posedge clk) begin
        if (!resetH && state == WRITE) begin
            mem[beatAddr] <= bus.AddrData;
        end
    end

    // Transaction sequencer with registered busy, error pulse and read drive enable.
    always_ff @(posedge clk) begin
        if (resetH) begin
            state         <= IDLE;
            beat          <= '0;
            bus.busy      <= 1'b0;
            bus.proto_err <= 1'b0;
            bus.readOe    <= 1'b0;
        end else begin
            // An address strobe while owning the bus is flagged and otherwise ignored.
            bus.proto_err <= bus.AddrValid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.AddrValid && pageHit) begin
                        base     <= addrOff;
                        beat     <= '0;
                        bus.busy <= 1'b1;
                        state    <= bus.rw ? TURN : WRITE;
                    end
                end
                WRITE: begin
                    if (lastBeat) begin
                        state    <= IDLE;
                        beat     <= '0;
                        bus.busy <= 1'b0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                TURN: begin
                    state        <= READ;
                    beat         <= '0;
                    bus.readOe   <= 1'b1;
                    bus.readData <= mem[fetchAddr];
                end
                READ: begin
                    if (lastBeat) begin
                        state      <= IDLE;
                        beat       <= '0;
                        bus.busy   <= 1'b0;
                        bus.readOe <= 1'b0;
                    end else begin
                        beat         <= beat + 1'b1;
                        bus.readData <= mem[fetchAddr];
                    end
                end
                default: begin
                    state      <= IDLE;
                    beat       <= '0;
                    bus.busy   <= 1'b0;
                    bus.readOe <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mainbus_burst_mem.sv
// tb/tb_mainbus_burst_mem.sv - randomized self-checking bench for mainbus_burst_mem
module tb_mainbus_burst_mem;
    localparam int DATA_W    = 16;
    localparam int PAGE_BITS = 4;
    localparam int PAGE_ID   = 2;
    localparam int BURST_LEN = 4;
    localparam int DEPTH     = 1 << (DATA_W - PAGE_BITS);

    logic clk = 1'b0;
    logic resetH = 1'b1;

    mainbus_burst_mem_if #(.DATA_W(DATA_W)) bus ();

    mainbus_burst_mem #(
        .DATA_W(DATA_W), .PAGE_BITS(PAGE_BITS), .PAGE_ID(PAGE_ID), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk(clk), .resetH(resetH), .bus(bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass = 0;

    logic [15:0] refMem [DEPTH];
    bit          refKnown [DEPTH];

    logic [15:0] obsData;
    logic        obsBusy, obsErr, obsOe;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] mkAddr(input int page, input int off);
        return {4'(page), 12'(off)};
    endfunction

    // One bus cycle: inputs applied just after the rising edge, outputs sampled at the falling edge.
    task automatic busCycle(input logic av, input logic rwIn, input logic drive, input logic [15:0] data);
        bus.AddrValid  = av;
        bus.rw         = rwIn;
        bus.masterOe   = drive;
        bus.masterData = data;
        @(negedge clk);
        obsData = bus.AddrData;
        obsBusy = bus.busy;
        obsErr  = bus.proto_err;
        obsOe   = bus.readOe;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        busCycle(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic expectIdle(input string tag);
        checkVal({tag, " busy"}, obsBusy, 1'b0);
        checkVal({tag, " proto_err"}, obsErr, 1'b0);
        checkVal({tag, " drive"}, obsOe, 1'b0);
    endtask

    // Write burst; errBeat >= 0 raises a stray AddrValid on that data beat.
    task automatic doWrite(input int off, input logic [15:0] d [BURST_LEN], input int errBeat);
        int a;
        busCycle(1'b1, 1'b0, 1'b1, mkAddr(PAGE_ID, off));
        checkVal("wr addr-cycle drive", obsOe, 1'b0);
        for (int i = 0; i < BURST_LEN; i++) begin
            busCycle(i == errBeat, 1'($urandom), 1'b1, d[i]);
            checkVal($sformatf("wr beat%0d busy", i), obsBusy, 1'b1);
            checkVal($sformatf("wr beat%0d drive", i), obsOe, 1'b0);
            checkVal($sformatf("wr beat%0d proto_err", i), obsErr, (errBeat >= 0 && i == errBeat + 1));
            a = (off + i) % DEPTH;
            refMem[a] = d[i];
            refKnown[a] = 1'b1;
        end
    endtask

    task automatic doRead(input int off);
        int a;
        busCycle(1'b1, 1'b1, 1'b1, mkAddr(PAGE_ID, off));
        checkVal("rd addr-cycle drive", obsOe, 1'b0);
        idleCycle();
        checkVal("rd turn busy", obsBusy, 1'b1);
        checkVal("rd turn drive", obsOe, 1'b0);
        for (int i = 0; i < BURST_LEN; i++) begin
            idleCycle();
            checkVal($sformatf("rd beat%0d busy", i), obsBusy, 1'b1);
            checkVal($sformatf("rd beat%0d drive", i), obsOe, 1'b1);
            a = (off + i) % DEPTH;
            if (refKnown[a]) checkVal($sformatf("rd beat%0d data @%0h", i, a), obsData, refMem[a]);
        end
    endtask

    initial begin
        logic [15:0] d [BURST_LEN];
        int bases[$];
        int off, op, pg;

        bus.AddrValid = 1'b0; bus.rw = 1'b0; bus.masterOe = 1'b0; bus.masterData = '0;
        @(posedge clk); #1;
        idleCycle();
        idleCycle();
        expectIdle("reset");
        resetH = 1'b0;
        idleCycle();
        expectIdle("post-reset");

        // Write then read, with the bus released on both sides of the read data.
        d = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        doWrite(12'h010, d, -1);
        idleCycle();
        expectIdle("t1 gap");
        doRead(12'h010);
        idleCycle();
        expectIdle("t1 after read");

        // Offset wrap stays inside the page.
        d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        doWrite(12'hFFE, d, -1);
        idleCycle();
        doRead(12'h000);
        idleCycle();
        doRead(12'hFFE);
        idleCycle();

        // Foreign page is ignored silently.
        busCycle(1'b1, 1'b1, 1'b1, 16'h3010);
        expectIdle("t3 addr");
        for (int i = 0; i < 4; i++) begin
            idleCycle();
            expectIdle($sformatf("t3 wait%0d", i));
        end
        doRead(12'h010);
        idleCycle();

        // Stray AddrValid during write beat 2: data still written, one-cycle error, no new transaction.
        d = '{16'h5001, 16'h5002, 16'hBEEF, 16'h5004};
        doWrite(12'h020, d, 2);
        idleCycle();
        expectIdle("t4 after write");
        idleCycle();
        expectIdle("t4 no new txn");
        doRead(12'h020);
        idleCycle();

        // Reset during read beat 1 releases the bus next cycle and keeps memory.
        foreach (d[k]) d[k] = 16'($urandom);
        doWrite(12'h040, d, -1);
        idleCycle();
        busCycle(1'b1, 1'b1, 1'b1, mkAddr(PAGE_ID, 12'h040));
        idleCycle();
        idleCycle();
        checkVal("t5 beat0 data", obsData, refMem[12'h040]);
        resetH = 1'b1;
        idleCycle();
        checkVal("t5 beat1 data", obsData, refMem[12'h041]);
        resetH = 1'b0;
        idleCycle();
        expectIdle("t5 after reset");
        doRead(12'h040);
        idleCycle();

        // Back-to-back: read issued in the first idle cycle after the write.
        foreach (d[k]) d[k] = 16'($urandom);
        doWrite(12'h080, d, -1);
        doRead(12'h080);
        idleCycle();
        expectIdle("t6 after read");

        // Randomized traffic against the reference memory.
        bases = '{12'h010, 12'hFFE, 12'h020, 12'h040, 12'h080};
        for (int t = 0; t < 40; t++) begin
            op = $urandom_range(0, 9);
            if (op == 0) begin
                pg = $urandom_range(0, 15);
                if (pg == PAGE_ID) pg = PAGE_ID + 1;
                busCycle(1'b1, 1'($urandom), 1'b1, mkAddr(pg, $urandom_range(0, DEPTH - 1)));
                expectIdle("rnd foreign addr");
                idleCycle();
                expectIdle("rnd foreign after");
            end else if (op <= 4) begin
                off = $urandom_range(0, DEPTH - 1);
                foreach (d[k]) d[k] = 16'($urandom);
                doWrite(off, d, -1);
                bases.push_back(off);
            end else begin
                off = bases[$urandom_range(0, bases.size() - 1)];
                if ($urandom_range(0, 3) == 0) off = (off + $urandom_range(1, 3)) % DEPTH;
                doRead(off);
            end
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                idleCycle();
                expectIdle("rnd gap");
            end
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
